// File: rtl/rr_stream_arbiter.sv
// Packet-aware round-robin arbiter feeding one registered valid/ready output stage.
// state  | meaning
// IDLE   | no packet in flight; grant goes to the next valid requester after ptr
// LOCKED | mid-packet; only lock_id may send until its last beat is accepted
module rr_stream_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   localparam int SRC_W     = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            in_valid,
   output logic [NUM_REQ-1:0]            in_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]            in_last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_last,
   output logic [SRC_W-1:0]              out_src
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                 state;
   logic [SRC_W-1:0]       ptr;
   logic [SRC_W-1:0]       lock_id;

   logic                   stage_free;
   logic                   grant_valid;
   logic [SRC_W-1:0]       grant;
   logic [2*NUM_REQ-1:0]   dbl_valid;
   int                     off;
   int                     pos;
   logic                   sel_valid;
   logic                   sel_last;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   accept;

   assign stage_free = !out_valid || out_ready;

   // Rotate the valids so bit 0 is the requester right after ptr; lowest set bit wins.
   always_comb begin
      grant_valid = 1'b0;
      grant       = '0;
      off         = 0;
      pos         = 0;
      dbl_valid   = {in_valid, in_valid} >> (int'(ptr) + 1);
      if (state == LOCKED) begin
         grant_valid = 1'b1;
         grant       = lock_id;
      end else begin
         for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (dbl_valid[j]) begin
               grant_valid = 1'b1;
               off         = j;
            end
         end
         pos = int'(ptr) + 1 + off;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         grant = SRC_W'(pos);
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      in_ready  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == SRC_W'(i)) begin
            sel_valid = in_valid[i];
            sel_last  = in_last[i];
            sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            in_ready[i] = grant_valid && stage_free && !rst;
         end
      end
   end

   assign accept = grant_valid && sel_valid && stage_free && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_src   <= '0;
         state     <= IDLE;
         ptr       <= SRC_W'(NUM_REQ - 1);
         lock_id   <= '0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= grant;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // ptr only moves on packet completion so a partial packet never shifts priority.
         case (state)
            IDLE: begin
               if (accept) begin
                  if (sel_last) begin
                     ptr <= grant;
                  end else begin
                     state   <= LOCKED;
                     lock_id <= grant;
                  end
               end
            end
            LOCKED: begin
               if (accept && sel_last) begin
                  state <= IDLE;
                  ptr   <= lock_id;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: round-robin order, packet locking,
// backpressure hold, stalled locked requester and reset mid-packet.
module tb_rr_stream_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 32;
   localparam int SRC_W      = 2;

   logic                          clk = 1'b0;
   logic                          rst;
   logic [NUM_REQ-1:0]            in_valid;
   logic [NUM_REQ-1:0]            in_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
   logic [NUM_REQ-1:0]            in_last;
   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_WIDTH-1:0]         out_data;
   logic                          out_last;
   logic [SRC_W-1:0]              out_src;

   int checks = 0;
   int errors = 0;

   rr_stream_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [31:0] d, input logic l);
      in_valid[i] = v;
      in_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
      in_last[i]  = l;
   endtask

   task automatic check_ready(input string tag, input logic [3:0] exp);
      #1;
      check(tag, 64'(in_ready), 64'(exp));
   endtask

   task automatic check_out(input string tag, input logic v, input logic [1:0] src,
                            input logic [31:0] d, input logic l);
      check({tag, ".valid"}, 64'(out_valid), 64'(v));
      check({tag, ".src"},   64'(out_src),   64'(src));
      check({tag, ".data"},  64'(out_data),  64'(d));
      check({tag, ".last"},  64'(out_last),  64'(l));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      in_last   = '0;
      out_ready = 1'b1;

      // 1: reset, in_ready forced low during reset, then 10 quiet idle cycles
      tick();
      in_valid = 4'hF;
      check_ready("rst_ready", 4'h0);
      tick();
      check_out("rst_out", 1'b0, 2'd0, 32'h0, 1'b0);
      in_valid = '0;
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         check_ready("idle_ready", 4'h0);
         tick();
         check("idle_valid", 64'(out_valid), 64'd0);
      end

      // 2: all four valid with single-beat packets -> 0,1,2,3,0,1 back to back
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'h100 + 32'(i), 1'b1);
      for (int k = 0; k < 6; k++) begin
         check_ready("rr_ready", 4'(1 << (k % 4)));
         tick();
         check_out("rr_out", 1'b1, 2'(k % 4), 32'h100 + 32'(k % 4), 1'b1);
      end
      in_valid = '0;
      check_ready("rr_drain_ready", 4'h0);
      tick();
      check("drain_valid", 64'(out_valid), 64'd0);
      check("drain_hold", 64'(out_data), 64'h101);

      // single beat from req0 moves ptr to 0 so req1 wins next
      set_req(0, 1'b1, 32'h55, 1'b1);
      check_ready("r0_ready", 4'h1);
      tick();
      check_out("r0_out", 1'b1, 2'd0, 32'h55, 1'b1);
      in_valid = '0;
      tick();

      // 3: req1 4-beat packet with req2 continuously valid
      set_req(2, 1'b1, 32'h200, 1'b1);
      for (int b = 0; b < 4; b++) begin
         set_req(1, 1'b1, 32'h10 + 32'(b), (b == 3));
         check_ready("pkt_ready", 4'h2);
         tick();
         check_out("pkt_out", 1'b1, 2'd1, 32'h10 + 32'(b), (b == 3));
      end
      in_valid[1] = 1'b0;
      check_ready("after_pkt_ready", 4'h4);
      tick();
      check_out("after_pkt_out", 1'b1, 2'd2, 32'h200, 1'b1);
      in_valid = '0;
      tick();

      // 4: backpressure holds 0xAA and blocks all requesters
      set_req(3, 1'b1, 32'hAA, 1'b1);
      check_ready("bp_first_ready", 4'h8);
      tick();
      check_out("bp_first_out", 1'b1, 2'd3, 32'hAA, 1'b1);
      set_req(3, 1'b1, 32'hAB, 1'b1);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         check_ready("bp_hold_ready", 4'h0);
         tick();
         check_out("bp_hold_out", 1'b1, 2'd3, 32'hAA, 1'b1);
      end
      out_ready = 1'b1;
      check_ready("bp_release_ready", 4'h8);
      tick();
      check_out("bp_next_out", 1'b1, 2'd3, 32'hAB, 1'b1);
      in_valid = '0;
      tick();

      // 5: locked req3 stalls mid-packet; req0 must wait for req3's last beat
      set_req(3, 1'b1, 32'h30, 1'b0);
      check_ready("lk_b0_ready", 4'h8);
      tick();
      check_out("lk_b0_out", 1'b1, 2'd3, 32'h30, 1'b0);
      set_req(0, 1'b1, 32'h0A, 1'b1);
      set_req(3, 1'b1, 32'h31, 1'b0);
      check_ready("lk_b1_ready", 4'h8);
      tick();
      check_out("lk_b1_out", 1'b1, 2'd3, 32'h31, 1'b0);
      in_valid[3] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         check_ready("lk_gap_ready", 4'h8);
         tick();
         check("lk_gap_valid", 64'(out_valid), 64'd0);
      end
      set_req(3, 1'b1, 32'h32, 1'b1);
      check_ready("lk_end_ready", 4'h8);
      tick();
      check_out("lk_end_out", 1'b1, 2'd3, 32'h32, 1'b1);
      in_valid[3] = 1'b0;
      check_ready("lk_next_ready", 4'h1);
      tick();
      check_out("lk_next_out", 1'b1, 2'd0, 32'h0A, 1'b1);
      in_valid = '0;
      tick();

      // 6: reset while locked on req2 with a beat held
      set_req(2, 1'b1, 32'h20, 1'b0);
      check_ready("rs_lock_ready", 4'h4);
      tick();
      check_out("rs_lock_out", 1'b1, 2'd2, 32'h20, 1'b0);
      rst = 1'b1;
      check_ready("rs_assert_ready", 4'h0);
      tick();
      check_out("rs_after_out", 1'b0, 2'd0, 32'h0, 1'b0);
      rst = 1'b0;
      set_req(0, 1'b1, 32'h0B, 1'b1);
      set_req(2, 1'b1, 32'h21, 1'b1);
      check_ready("rs_first_ready", 4'h1);
      tick();
      check_out("rs_first_out", 1'b1, 2'd0, 32'h0B, 1'b1);
      in_valid[0] = 1'b0;
      check_ready("rs_second_ready", 4'h4);
      tick();
      check_out("rs_second_out", 1'b1, 2'd2, 32'h21, 1'b1);
      in_valid = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Round-robin arbiter that shares one registered valid/ready output stage among NUM_REQ streaming requesters.
- Packet-aware: once a requester is granted, it keeps the stage until a beat with in_last is accepted, so packets are never interleaved.
- Output is a full-throughput single pipeline stage: one beat per cycle, 1-cycle latency.
- Sits in front of a shared downstream consumer, e.g. a common processing pipe fed by several producers.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_WIDTH, 32, payload width per beat.
- SRC_W, $clog2(NUM_REQ), localparam, width of the source-ID field.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  NUM_REQ  per-requester beat valid.
- in_ready  out  NUM_REQ  per-requester beat accept; at most one bit set.
- in_data  in  NUM_REQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_last  in  NUM_REQ  per-requester end-of-packet flag.
- out_valid  out  1  output stage holds a beat.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  registered payload.
- out_last  out  1  registered end-of-packet flag.
- out_src  out  SRC_W  index of the requester that produced the beat.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE, ptr=NUM_REQ-1 (first search starts at requester 0).
- in_ready is forced to all zeros while rst=1.
- stage_free = !out_valid || out_ready.
- Grant selection, state IDLE:
  - grant = first i with in_valid[i]=1, searching (ptr+1) mod NUM_REQ upward with wrap-around.
  - Selection is combinational, so a beat is accepted in the same cycle as the grant.
  - If no requester is valid, there is no grant.
- Grant selection, state LOCKED: grant = lock_id, regardless of other valids.
- in_ready[grant] = stage_free. All other in_ready bits are 0.
- Accept, when in_valid[g] && in_ready[g]:
  - Next edge: out_data <= in_data[g], out_last <= in_last[g], out_src <= g, out_valid <= 1.
- Drain, when out_valid && out_ready and no accept: out_valid <= 0. Data registers hold their values.
- Simultaneous drain and accept: the new beat replaces the old one and out_valid stays 1. Throughput is 1 beat/cycle with no bubble.
- Output hold: while out_valid && !out_ready, out_data, out_last and out_src are stable and every in_ready is 0.
- State machine:
  - IDLE, accept with in_last=0: go to LOCKED with lock_id <= g.
  - IDLE, accept with in_last=1: stay IDLE; ptr <= g (single-beat packet).
  - LOCKED, accept with in_last=1: go to IDLE; ptr <= lock_id.
  - LOCKED, any other case: stay LOCKED. This includes the locked requester dropping in_valid mid-packet; other requesters stay blocked.
- ptr updates only when a packet completes, never on partial packets. This guarantees fairness: after requester k finishes, k has lowest priority.
- Reset mid-packet: returns to IDLE and ptr=NUM_REQ-1; any partially forwarded packet is truncated. Upstream and downstream must be reset together.
- Latency: input accept to out_valid is exactly 1 cycle.
- No combinational path from in_* to out_*. The only combinational paths are in_valid/out_ready to in_ready.

Test Plan:
1. Reset release, all in_valid=0 -> out_valid=0, in_ready=0000, out_src=0; state stays IDLE for 10 cycles.
2. Requesters 0..3 all valid with single-beat packets (in_last=1), out_ready=1 -> out_src sequence is 0,1,2,3,0,1 on consecutive cycles, with no bubbles.
3. Req1 sends a 4-beat packet (data 0x10..0x13) while req2 is continuously valid -> out_data=0x10,0x11,0x12,0x13 from src 1, then src 2. in_ready[2]=0 throughout req1's packet.
4. Backpressure: out_ready=0 for 3 cycles while out_valid=1 with out_data=0xAA -> out_data stays 0xAA and in_ready=0000. After out_ready=1, the next beat follows in the next cycle.
5. Locked req3 drops in_valid for 2 cycles mid-packet while req0 is valid -> no beats from req0 are forwarded until req3 sends its in_last beat. Next grant is then req0.
6. Assert rst for 1 cycle while LOCKED on req2 with out_valid=1 -> next cycle out_valid=0 and state=IDLE. Requesters 0 and 2 both valid after release -> req0 is granted first.
